// File: rtl/apb_master.sv
// APB master bridging level-sensitive processor read/write requests onto an
// APB bus with two peripheral selects, wait-state timeout and error reporting.
module apb_master #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        wr_en,
    input  logic [8:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_done,
    input  logic        rd_en,
    input  logic [8:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        rd_done,
    output logic        err,
    output logic [7:0]  paddr,
    output logic        psel1,
    output logic        psel2,
    output logic        penable,
    output logic        pwrite,
    output logic [15:0] pwdata,
    input  logic [15:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [8:0]      addr_q, addr_d;
    logic [15:0]     data_q, data_d;
    logic            write_q, write_d;
    logic            wr_arm_q, wr_arm_d;
    logic            rd_arm_q, rd_arm_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            err_q, err_d;
    logic [15:0]     rd_data_q, rd_data_d;
    logic            active;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            wr_arm_q  <= 1'b1;
            rd_arm_q  <= 1'b1;
            wait_q    <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            write_q   <= write_d;
            wr_arm_q  <= wr_arm_d;
            rd_arm_q  <= rd_arm_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        write_d   = write_q;
        wait_d    = wait_q;
        err_d     = err_q;
        rd_data_d = rd_data_q;
        // An enable seen low re-arms its direction; launching disarms it.
        wr_arm_d  = wr_arm_q | ~wr_en;
        rd_arm_d  = rd_arm_q | ~rd_en;
        unique case (state_q)
            IDLE: begin
                if (wr_en && wr_arm_q) begin
                    state_d  = SETUP;
                    addr_d   = wr_addr;
                    data_d   = wr_data;
                    write_d  = 1'b1;
                    wr_arm_d = 1'b0;
                end else if (rd_en && rd_arm_q) begin
                    state_d  = SETUP;
                    addr_d   = rd_addr;
                    data_d   = '0;
                    write_d  = 1'b0;
                    rd_arm_d = 1'b0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                wait_d  = '0;
                err_d   = 1'b0;
            end
            ACCESS: begin
                if (pready) begin
                    state_d = DONE;
                    err_d   = pslverr;
                    if (!write_q) rd_data_d = prdata;
                end else begin
                    wait_d = wait_q + CW'(1);
                    if (wait_d == CW'(TIMEOUT)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        if (!write_q) rd_data_d = 16'hDEAD;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign active  = (state_q == SETUP) || (state_q == ACCESS);
    assign psel1   = active & ~addr_q[8];
    assign psel2   = active & addr_q[8];
    assign penable = (state_q == ACCESS);
    assign pwrite  = active & write_q;
    assign paddr   = active ? addr_q[7:0] : 8'h00;
    assign pwdata  = (active && write_q) ? data_q : 16'h0000;
    assign wr_done = (state_q == DONE) & write_q;
    assign rd_done = (state_q == DONE) & ~write_q;
    assign err     = (state_q == DONE) & err_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: per-cycle bus phases, completion
// timing, timeout, slave error, arbitration, re-arm and async reset.
module tb_apb_master;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        wr_en = 1'b0;
    logic [8:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_done;
    logic        rd_en = 1'b0;
    logic [8:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_done;
    logic        err;
    logic [7:0]  paddr;
    logic        psel1;
    logic        psel2;
    logic        penable;
    logic        pwrite;
    logic [15:0] pwdata;
    logic [15:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_rd = '0;

    apb_master #(.TIMEOUT(TMO)) dut (
        .clk(clk), .nreset(nreset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_done(wr_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_done(rd_done), .err(err),
        .paddr(paddr), .psel1(psel1), .psel2(psel2),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    // One transfer; the bus phase of each cycle after the sample edge is
    // derived from the wait count: SETUP at 1, ACCESS up to done, DONE at dk.
    task automatic run_xfer(input string nm, input bit wr,
                            input logic [8:0] a, input logic [15:0] d,
                            input logic [15:0] rv, input int nw,
                            input bit se);
        int dk;
        bit to, act, acc, dn;
        logic [6:0] ev, ov;
        to = (nw >= TMO);
        dk = to ? 2 + TMO : 3 + nw;
        @(negedge clk);
        if (wr) begin
            wr_en = 1'b1; wr_addr = a; wr_data = d;
        end else begin
            rd_en = 1'b1; rd_addr = a;
        end
        pready = 1'b0;
        pslverr = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= dk + 1; k++) begin
            @(negedge clk);
            wr_en = 1'b0;
            rd_en = 1'b0;
            act = (k < dk);
            acc = (k >= 2) && (k < dk);
            dn  = (k == dk);
            ev = {act & ~a[8], act & a[8], acc, act & wr,
                  dn & wr, dn & ~wr, dn & (to | se)};
            ov = {psel1, psel2, penable, pwrite, wr_done, rd_done, err};
            checks++;
            if (ov !== ev) begin
                errors++;
                $display("FAIL %s ctl k=%0d got %b exp %b", nm, k, ov, ev);
            end
            if (act) begin
                checks++;
                if (paddr !== a[7:0] || pwdata !== (wr ? d : 16'h0)) begin
                    errors++;
                    $display("FAIL %s bus k=%0d got %h/%h exp %h/%h", nm, k,
                             paddr, pwdata, a[7:0], (wr ? d : 16'h0));
                end
            end
            if (dn && !wr) exp_rd = to ? 16'hDEAD : rv;
            if (dn) begin
                checks++;
                if (rd_data !== exp_rd) begin
                    errors++;
                    $display("FAIL %s rd_data got %h exp %h", nm, rd_data,
                             exp_rd);
                end
            end
            pready  = !to && (k == 2 + nw);
            pslverr = pready ? se : 1'($urandom);
            prdata  = pready ? rv : 16'($urandom);
        end
        pready = 1'b0;
        pslverr = 1'b0;
    endtask

    task automatic test_reset();
        logic [46:0] ov;
        repeat (2) @(negedge clk);
        ov = {psel1, psel2, penable, pwrite, wr_done, rd_done, err,
              paddr, pwdata, rd_data};
        checks++;
        if (ov !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", ov);
        end
        wr_en = 1'b1; wr_addr = 9'h0F0; wr_data = 16'h1234;
        #1 nreset = 1'b1;
        #1;
        checks++;
        if (psel1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early psel1 got %b exp 0", psel1);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({psel1, penable, paddr} !== {1'b1, 1'b0, 8'hF0}) begin
            errors++;
            $display("FAIL reset_first_edge got %b%b%h exp 10f0", psel1,
                     penable, paddr);
        end
        wr_en = 1'b0;
        pready = 1'b1;
        repeat (4) @(negedge clk);
        pready = 1'b0;
    endtask

    task automatic test_write();
        run_xfer("write", 1'b1, 9'h012, 16'hA5A5, 16'h0, 0, 1'b0);
    endtask

    task automatic test_kmi_read();
        run_xfer("kmi_read", 1'b0, 9'h100, 16'hBEEF, 16'h001C, 3, 1'b0);
    endtask

    task automatic test_random();
        bit wr, se;
        logic [8:0] a;
        logic [15:0] d, rv;
        int nw;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 9'($urandom);
            d  = 16'($urandom);
            rv = 16'($urandom);
            nw = $urandom_range(0, 5);
            se = ($urandom_range(0, 3) == 0);
            run_xfer("random", wr, a, d, rv, nw, se);
        end
    endtask

    task automatic test_timeout();
        run_xfer("wait_14", 1'b0, 9'h155, 16'h0, 16'h7777, TMO - 1, 1'b0);
        run_xfer("tmo_read", 1'b0, 9'h044, 16'h0, 16'h1111, TMO, 1'b0);
        run_xfer("tmo_write", 1'b1, 9'h1A0, 16'hC3C3, 16'h0, 40, 1'b0);
    endtask

    task automatic test_slverr();
        run_xfer("slverr_rd", 1'b0, 9'h0C0, 16'h0, 16'h4242, 1, 1'b1);
        run_xfer("slverr_wr", 1'b1, 9'h1C1, 16'h9999, 16'h0, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ev, ov;
        bit wa, ra, wd, rdn, wacc, racc;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 9'h0AB; wr_data = 16'h6161;
        rd_en = 1'b1; rd_addr = 9'h1CD;
        prdata = 16'h5A3C;
        pready = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (k == 5) rd_en = 1'b0;
            wa = (k <= 2); wacc = (k == 2); wd = (k == 3);
            ra = (k == 5) || (k == 6); racc = (k == 6); rdn = (k == 7);
            ev = {wa, ra, wacc | racc, wa, wd, rdn, 1'b0};
            ov = {psel1, psel2, penable, pwrite, wr_done, rd_done, err};
            checks++;
            if (ov !== ev) begin
                errors++;
                $display("FAIL b2b k=%0d got %b exp %b", k, ov, ev);
            end
            if (wa || ra) begin
                checks++;
                if (paddr !== (wa ? 8'hAB : 8'hCD)) begin
                    errors++;
                    $display("FAIL b2b_addr k=%0d got %h", k, paddr);
                end
            end
            if (rdn) begin
                exp_rd = 16'h5A3C;
                checks++;
                if (rd_data !== exp_rd) begin
                    errors++;
                    $display("FAIL b2b_rd got %h exp %h", rd_data, exp_rd);
                end
            end
        end
        pready = 1'b0;
    endtask

    task automatic test_hold();
        int setups, dones;
        setups = 0;
        dones = 0;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 9'h077; wr_data = 16'h0F0F;
        pready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (psel1 && !penable) setups++;
            if (wr_done) dones++;
        end
        checks++;
        if (setups != 1 || dones != 1) begin
            errors++;
            $display("FAIL hold_once got %0d/%0d exp 1/1", setups, dones);
        end
        wr_en = 1'b0;
        pready = 1'b0;
        repeat (2) @(negedge clk);
        run_xfer("rearm", 1'b1, 9'h078, 16'hF0F0, 16'h0, 1, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [46:0] ov;
        bit bad;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 9'h033; wr_data = 16'h3333;
        pready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (penable !== 1'b1) begin
            errors++;
            $display("FAIL areset_access penable got %b exp 1", penable);
        end
        #1 nreset = 1'b0;
        #1;
        ov = {psel1, psel2, penable, pwrite, wr_done, rd_done, err,
              paddr, pwdata, rd_data};
        checks++;
        if (ov !== '0) begin
            errors++;
            $display("FAIL areset_async got %h exp 0", ov);
        end
        exp_rd = 16'h0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if ({psel1, psel2, penable, wr_done, rd_done, err} !== '0)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL areset_no_done got activity exp none");
        end
        run_xfer("post_reset", 1'b0, 9'h1EE, 16'h0, 16'h2468, 2, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_kmi_read();
        test_random();
        test_timeout();
        test_slverr();
        test_back_to_back();
        test_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
